// File: rtl/alu_pkg.sv
// Shared ALU constants: widths, opcode encoding and controller state encoding.
package alu_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OPW    = 3;
   localparam int unsigned FLAG_W = 4;

   localparam logic [OPW-1:0] OP_AND = 3'd0;
   localparam logic [OPW-1:0] OP_OR  = 3'd1;
   localparam logic [OPW-1:0] OP_XOR = 3'd2;
   localparam logic [OPW-1:0] OP_ADD = 3'd3;
   localparam logic [OPW-1:0] OP_SUB = 3'd4;
   localparam logic [OPW-1:0] OP_NOT = 3'd5;
   localparam logic [OPW-1:0] OP_SLL = 3'd6;
   localparam logic [OPW-1:0] OP_SRL = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_RESP  = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: rr=0 prefers requester 0, rr=1 prefers requester 1.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       rr,
   output logic [1:0] gnt_c
);

   // Preferred requester wins if asking, otherwise the other one.
   always_comb begin
      gnt_c = 2'b00;
      if (rr == 1'b0) begin
         if (req[0])      gnt_c = 2'b01;
         else if (req[1]) gnt_c = 2'b10;
      end else begin
         if (req[1])      gnt_c = 2'b10;
         else if (req[0]) gnt_c = 2'b01;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Time-shares one combinational ALU between two requesters: arbitrate, capture
// operands, evaluate for one cycle, hold result and flags until acknowledged.
module alu_share_ctrl #(
   parameter int unsigned WIDTH = alu_pkg::DATA_W,
   parameter int unsigned OPW   = alu_pkg::OPW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [OPW-1:0]   op0,
   input  logic [OPW-1:0]   op1,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic [1:0]       ack,
   output logic [OPW-1:0]   alu_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   input  logic [WIDTH-1:0] alu_r,
   input  logic [3:0]       alu_nzcv,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       nzcv
);

   import alu_pkg::*;

   state_t           state_q, state_d;
   logic             rr_q, rr_d;
   logic [1:0]       pick_c;
   logic [1:0]       gnt_d, done_d;
   logic [OPW-1:0]   alu_op_d;
   logic [WIDTH-1:0] alu_a_d, alu_b_d, result_d;
   logic [3:0]       nzcv_d;

   rr_arb2 u_arb (
      .req   (req),
      .rr    (rr_q),
      .gnt_c (pick_c)
   );

   // Next-state and next-output logic; every register holds unless updated.
   always_comb begin
      state_d  = state_q;
      rr_d     = rr_q;
      gnt_d    = gnt;
      done_d   = done;
      alu_op_d = alu_op;
      alu_a_d  = alu_a;
      alu_b_d  = alu_b;
      result_d = result;
      nzcv_d   = nzcv;
      case (state_q)
         ST_IDLE: begin
            if (req != 2'b00) begin
               gnt_d    = pick_c;
               alu_op_d = pick_c[1] ? op1 : op0;
               alu_a_d  = pick_c[1] ? a1  : a0;
               alu_b_d  = pick_c[1] ? b1  : b0;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            result_d = alu_r;
            nzcv_d   = alu_nzcv;
            done_d   = gnt;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            // Only the granted requester's ack releases the ALU.
            if ((ack & gnt) != 2'b00) begin
               done_d  = 2'b00;
               gnt_d   = 2'b00;
               rr_d    = gnt[0];
               state_d = ST_IDLE;
            end
         end
         default: begin
            gnt_d   = 2'b00;
            done_d  = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rr_q    <= 1'b0;
         gnt     <= 2'b00;
         done    <= 2'b00;
         alu_op  <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         result  <= '0;
         nzcv    <= 4'b0000;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         gnt     <= gnt_d;
         done    <= done_d;
         alu_op  <= alu_op_d;
         alu_a   <= alu_a_d;
         alu_b   <= alu_b_d;
         result  <= result_d;
         nzcv    <= nzcv_d;
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural shared ALU.
module tb_alu_share_ctrl;

   import alu_pkg::*;

   localparam int unsigned W = DATA_W;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     req, ack;
   logic [OPW-1:0] op0, op1;
   logic [W-1:0]   a0, b0, a1, b1;
   logic [OPW-1:0] alu_op;
   logic [W-1:0]   alu_a, alu_b, alu_r;
   logic [3:0]     alu_nzcv;
   logic [1:0]     gnt, done;
   logic [W-1:0]   result;
   logic [3:0]     nzcv;
   logic           alu_c, alu_v;
   logic [W:0]     wide;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   alu_share_ctrl dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .op0      (op0),
      .op1      (op1),
      .a0       (a0),
      .b0       (b0),
      .a1       (a1),
      .b1       (b1),
      .ack      (ack),
      .alu_op   (alu_op),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_r    (alu_r),
      .alu_nzcv (alu_nzcv),
      .gnt      (gnt),
      .done     (done),
      .result   (result),
      .nzcv     (nzcv)
   );

   // Shared ALU model.
   always_comb begin
      wide  = '0;
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (alu_op)
         OP_AND: alu_r = alu_a & alu_b;
         OP_OR:  alu_r = alu_a | alu_b;
         OP_XOR: alu_r = alu_a ^ alu_b;
         OP_ADD: begin
            wide  = {1'b0, alu_a} + {1'b0, alu_b};
            alu_r = wide[W-1:0];
            alu_c = wide[W];
            alu_v = (alu_a[W-1] == alu_b[W-1]) && (wide[W-1] != alu_a[W-1]);
         end
         OP_SUB: begin
            wide  = {1'b0, alu_a} - {1'b0, alu_b};
            alu_r = wide[W-1:0];
            alu_c = wide[W];
            alu_v = (alu_a[W-1] != alu_b[W-1]) && (wide[W-1] != alu_a[W-1]);
         end
         OP_NOT: alu_r = ~alu_a;
         OP_SLL: alu_r = alu_a << alu_b[4:0];
         default: alu_r = alu_a >> alu_b[4:0];
      endcase
   end

   assign alu_nzcv = {alu_r[W-1], (alu_r == '0), alu_c, alu_v};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction with ack in the first RESP cycle.
   task automatic run_op(input string tag, input logic [1:0] rq, input logic [1:0] eg,
                         input logic [W-1:0] er, input logic [3:0] en);
      req = rq;
      step();
      chk({tag, "_gnt"}, 64'(gnt), 64'(eg));
      chk({tag, "_done_early"}, 64'(done), 64'd0);
      step();
      chk({tag, "_done"}, 64'(done), 64'(eg));
      chk({tag, "_result"}, 64'(result), 64'(er));
      chk({tag, "_nzcv"}, 64'(nzcv), 64'(en));
      ack = eg;
      step();
      chk({tag, "_gnt_clr"}, 64'(gnt), 64'd0);
      chk({tag, "_done_clr"}, 64'(done), 64'd0);
      req = 2'b00;
      ack = 2'b00;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [1:0] eg;
      int         last_done;
      rst_n = 1'b0;
      req = 2'b00; ack = 2'b00;
      op0 = OP_AND; op1 = OP_AND;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (2) step();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_nzcv", 64'(nzcv), 64'd0);
      chk("rst_alu_op", 64'(alu_op), 64'd0);
      chk("rst_alu_a", 64'(alu_a), 64'd0);
      chk("rst_alu_b", 64'(alu_b), 64'd0);
      rst_n = 1'b1;
      step();

      // Single-requester transactions.
      a0 = 32'd1; b0 = 32'd1;
      run_op("t1", 2'b01, 2'b01, 32'd1, 4'b0000);
      a1 = 32'd2; b1 = 32'd1;
      run_op("t2", 2'b10, 2'b10, 32'd0, 4'b0100);
      a0 = 32'h8000_0000; b0 = 32'h8000_0000;
      run_op("t3", 2'b01, 2'b01, 32'h8000_0000, 4'b1000);

      // Fresh reset so contention starts from requester 0.
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      step();

      // Continuous contention: strict alternation, done every 3 cycles.
      a0 = 32'd5; b0 = 32'd3; a1 = 32'd6; b1 = 32'd3;
      req = 2'b11;
      last_done = 0;
      for (int i = 0; i < 4; i++) begin
         eg = (i % 2 == 0) ? 2'b01 : 2'b10;
         step();
         chk("t4_gnt", 64'(gnt), 64'(eg));
         step();
         chk("t4_done", 64'(done), 64'(eg));
         chk("t4_result", 64'(result), (eg == 2'b01) ? 64'd1 : 64'd2);
         if (i > 0) chk("t4_spacing", 64'(cyc - last_done), 64'd3);
         last_done = cyc;
         ack = eg;
         step();
         chk("t4_idle", 64'(gnt), 64'd0);
         ack = 2'b00;
      end
      req = 2'b00;
      step();

      // Held RESP: withheld and wrong-bit acks, req dropped, operands changed.
      a0 = 32'hF0F0_0000; b0 = 32'hFF00_FFFF;
      req = 2'b01;
      step();
      req = 2'b00;
      a0 = 32'h0000_0001;
      step();
      for (int i = 0; i < 5; i++) begin
         ack = (i % 2 == 0) ? 2'b10 : 2'b00;
         step();
         chk("t5_done_hold", 64'(done), 64'd1);
         chk("t5_result_hold", 64'(result), 64'hF000_0000);
      end
      chk("t5_nzcv", 64'(nzcv), 64'b1000);
      chk("t5_alu_a", 64'(alu_a), 64'hF0F0_0000);
      ack = 2'b01;
      step();
      chk("t5_done_clr", 64'(done), 64'd0);
      chk("t5_gnt_clr", 64'(gnt), 64'd0);
      ack = 2'b00;

      // Async reset during ISSUE.
      req = 2'b01;
      step();
      chk("t6_issue_gnt", 64'(gnt), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_gnt", 64'(gnt), 64'd0);
      chk("t6_rst_done", 64'(done), 64'd0);
      chk("t6_rst_result", 64'(result), 64'd0);
      chk("t6_rst_nzcv", 64'(nzcv), 64'd0);
      req = 2'b11;
      #1;
      rst_n = 1'b1;
      step();
      chk("t6_gnt_rr0", 64'(gnt), 64'd1);
      step();
      chk("t6_done", 64'(done), 64'd1);
      ack = 2'b01;
      req = 2'b00;
      step();
      chk("t6_done_clr", 64'(done), 64'd0);
      ack = 2'b00;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
